secuenciador_mult: RTL

- Operand sequencer placed directly upstream of the sequential Booth multiplier.
- Accepts signed operand pairs over a valid/ready handshake and launches the multiplier with a one-cycle start pulse.
- Waits for the multiplier's Fin rising edge, captures the product, and holds it on a valid/ready output until it is consumed.
- A watchdog flags a multiplier that never finishes.

---
 rtl/secuenciador_mult.sv | 145 ++++++++++++++
 1 files changed

// File: rtl/secuenciador_mult.sv
// Operand sequencer in front of a sequential Booth multiplier.
// Accepts one signed operand pair at a time, pulses the multiplier start,
// waits for a rising edge on Fin, and holds the product until it is consumed.
// A watchdog drops the operation and raises a sticky error if Fin never rises.
//
// Ports:
//   clk, rst                 clock, asynchronous active-high reset
//   in_a, in_b, in_valid     operand pair and its valid
//   in_ready                 sequencer is idle and can take a pair
//   mul_a, mul_b, mul_start  operands and one-cycle start pulse to multiplier
//   mul_fin, mul_res         multiplier done level and product
//   out_res, out_valid       captured product and its valid
//   out_ready                consumer accepts out_res
//   timeout_err              sticky watchdog error
//   op_count                 number of products delivered (wrapping)
module secuenciador_mult #(
  parameter int unsigned NUM_BITS = 4,
  parameter int unsigned TIMEOUT  = 64,
  parameter int unsigned CNT_BITS = 16
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [NUM_BITS-1:0]     in_a,
  input  logic [NUM_BITS-1:0]     in_b,
  input  logic                    in_valid,
  output logic                    in_ready,
  output logic [NUM_BITS-1:0]     mul_a,
  output logic [NUM_BITS-1:0]     mul_b,
  output logic                    mul_start,
  input  logic                    mul_fin,
  input  logic [2*NUM_BITS-1:0]   mul_res,
  output logic [2*NUM_BITS-1:0]   out_res,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic                    timeout_err,
  output logic [CNT_BITS-1:0]     op_count
);

  localparam int unsigned RES_W = 2 * NUM_BITS;
  localparam int unsigned WD_W  = $clog2(TIMEOUT + 1);
  localparam logic [WD_W-1:0] WD_LAST = WD_W'(TIMEOUT - 1);

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_LAUNCH,
    ST_WAIT,
    ST_HOLD
  } state_t;

  state_t              state_q, state_d;
  logic [NUM_BITS-1:0] mul_a_q, mul_a_d;
  logic [NUM_BITS-1:0] mul_b_q, mul_b_d;
  logic [RES_W-1:0]    out_res_q, out_res_d;
  logic                out_valid_q, out_valid_d;
  logic                timeout_err_q, timeout_err_d;
  logic [CNT_BITS-1:0] op_count_q, op_count_d;
  logic [WD_W-1:0]     wd_q, wd_d;
  logic                fin_q;
  logic                fin_rise;

  // Completion is an edge: a Fin left high from a previous op must not count.
  assign fin_rise = mul_fin & ~fin_q;

  // State and data registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q       <= ST_IDLE;
      mul_a_q       <= '0;
      mul_b_q       <= '0;
      out_res_q     <= '0;
      out_valid_q   <= 1'b0;
      timeout_err_q <= 1'b0;
      op_count_q    <= '0;
      wd_q          <= '0;
      fin_q         <= 1'b0;
    end else begin
      state_q       <= state_d;
      mul_a_q       <= mul_a_d;
      mul_b_q       <= mul_b_d;
      out_res_q     <= out_res_d;
      out_valid_q   <= out_valid_d;
      timeout_err_q <= timeout_err_d;
      op_count_q    <= op_count_d;
      wd_q          <= wd_d;
      fin_q         <= mul_fin;
    end
  end

  // Next-state and datapath update
  always_comb begin
    state_d       = state_q;
    mul_a_d       = mul_a_q;
    mul_b_d       = mul_b_q;
    out_res_d     = out_res_q;
    out_valid_d   = out_valid_q;
    timeout_err_d = timeout_err_q;
    op_count_d    = op_count_q;
    wd_d          = wd_q;

    case (state_q)
      ST_IDLE: begin
        if (in_valid) begin
          mul_a_d = in_a;
          mul_b_d = in_b;
          state_d = ST_LAUNCH;
        end
      end
      ST_LAUNCH: begin
        wd_d    = '0;
        state_d = ST_WAIT;
      end
      ST_WAIT: begin
        wd_d = wd_q + WD_W'(1);
        // A completion in the last watchdog cycle still counts as success.
        if (fin_rise) begin
          out_res_d   = mul_res;
          out_valid_d = 1'b1;
          state_d     = ST_HOLD;
        end else if (wd_q == WD_LAST) begin
          timeout_err_d = 1'b1;
          state_d       = ST_IDLE;
        end
      end
      ST_HOLD: begin
        if (out_ready) begin
          out_valid_d = 1'b0;
          op_count_d  = op_count_q + CNT_BITS'(1);
          state_d     = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // Handshake controls decode straight from the state register.
  assign in_ready    = (state_q == ST_IDLE);
  assign mul_start   = (state_q == ST_LAUNCH);
  assign mul_a       = mul_a_q;
  assign mul_b       = mul_b_q;
  assign out_res     = out_res_q;
  assign out_valid   = out_valid_q;
  assign timeout_err = timeout_err_q;
  assign op_count    = op_count_q;

endmodule
